vp_centroid: RTL and testbench

- Streaming centre-of-mass stage fed by the binarisation step of the video processing chain, using the same de/h_sync/v_sync timing.
- Accumulates coordinates of set mask pixels over one frame.
- At frame end, runs a serial division to produce the centroid (x, y).
- Result feeds the cross/circle visualisation overlay.

---
 rtl/vp_centroid_pkg.sv | 18 +
 rtl/vp_centroid_divider.sv | 68 ++++++
 rtl/vp_centroid.sv | 173 +++++++++++++++++
 tb/tb_vp_centroid.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_centroid_pkg.sv
// Shared defaults and FSM encodings for the vp_centroid centre-of-mass stage.
// Consumed by vp_centroid and its serial_divider.
`timescale 1ns/1ps
package vp_centroid_pkg;

    localparam int IMG_W_DEF    = 1280;
    localparam int IMG_H_DEF    = 720;
    localparam int COORD_W_DEF  = 11;
    localparam int SUM_W_DEF    = 31;
    localparam int CNT_W_DEF    = 20;
    localparam int MIN_AREA_DEF = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIV_X = 2'd1;
    localparam logic [1:0] ST_DIV_Y = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/vp_centroid_divider.sv
// Restoring serial divider: one quotient bit per cycle, MSB first.
// The start cycle already produces the first bit, so done rises N_W cycles after start.
`timescale 1ns/1ps
module serial_divider
    import vp_centroid_pkg::*;
#(
    parameter int N_W = SUM_W_DEF,
    parameter int D_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] numerator,
    input  logic [D_W-1:0] denominator,
    output logic [N_W-1:0] quotient,
    output logic           done
);

    localparam int LEFT_W = $clog2(N_W + 1);

    logic [D_W-1:0]    rem_q, den_q, rem_in, den_in, rem_next;
    logic [N_W-1:0]    num_q, quo_q, num_in, quo_in;
    logic [D_W:0]      shifted;
    logic [LEFT_W-1:0] left_q;
    logic              running_q, ge, step;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rem_in   = start ? '0 : rem_q;
        num_in   = start ? numerator : num_q;
        quo_in   = start ? '0 : quo_q;
        den_in   = start ? denominator : den_q;
        shifted  = {rem_in, num_in[N_W-1]};
        ge       = (shifted >= {1'b0, den_in});
        rem_next = ge ? D_W'(shifted - {1'b0, den_in}) : shifted[D_W-1:0];
        step     = start | (running_q && (left_q != '0));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            den_q     <= '0;
            num_q     <= '0;
            quo_q     <= '0;
            left_q    <= '0;
            running_q <= 1'b0;
        end else begin
            if (step) begin
                rem_q <= rem_next;
                den_q <= den_in;
                num_q <= num_in << 1;
                quo_q <= (quo_in << 1) | N_W'(ge);
            end
            if (start) begin
                running_q <= 1'b1;
                left_q    <= LEFT_W'(N_W - 1);
            end else if (running_q) begin
                if (left_q != '0) left_q <= left_q - 1'b1;
                else              running_q <= 1'b0;
            end
        end
    end

    assign quotient = quo_q;
    assign done     = running_q && (left_q == '0);

endmodule

// File: rtl/vp_centroid.sv
// Streaming centroid of a binary mask: accumulates set-pixel coordinates per frame,
// then divides serially at frame end. Optional VP_CENTROID_MIN_AREA_EN rejects small blobs.
`timescale 1ns/1ps
module vp_centroid
    import vp_centroid_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MIN_AREA = MIN_AREA_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_in,
    input  logic               h_sync_in,
    input  logic               v_sync_in,
    input  logic               mask_in,
    output logic [COORD_W-1:0] x_center,
    output logic [COORD_W-1:0] y_center,
    output logic               found,
    output logic               valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMG_H - 1);
    localparam logic [SUM_W-1:0]   Q_MAX = SUM_W'((64'd1 << COORD_W) - 64'd1);

    logic               de_q, vs_q, frame_end, line_end;
    logic [COORD_W-1:0] x_pos, y_pos, x_quo;
    logic [SUM_W-1:0]   sum_x, sum_y, snap_x, snap_y, div_num, div_quo;
    logic [CNT_W-1:0]   count, snap_cnt;
    logic [1:0]         state;
    logic               pend, engaged, nonempty, div_start, div_done;

    // Lines are delimited purely by de_in edges; h_sync is not needed.
    logic unused_h_sync;
    assign unused_h_sync = h_sync_in;

    assign frame_end = v_sync_in & ~vs_q;
    assign line_end  = de_q & ~de_in;
    assign busy      = (state != ST_IDLE);
    assign engaged   = busy | pend;

`ifdef VP_CENTROID_MIN_AREA_EN
    assign nonempty = (snap_cnt >= CNT_W'(MIN_AREA));
`else
    localparam int unused_min_area = MIN_AREA;
    assign nonempty = (snap_cnt != '0);
`endif

    function automatic logic [COORD_W-1:0] clamp_coord(input logic [SUM_W-1:0] q);
        if (q > Q_MAX) return {COORD_W{1'b1}};
        return q[COORD_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            x_pos <= '0;
            y_pos <= '0;
        end else begin
            de_q <= de_in;
            vs_q <= v_sync_in;
            if (frame_end) begin
                x_pos <= '0;
                y_pos <= '0;
            end else if (line_end) begin
                x_pos <= '0;
                if (y_pos != Y_MAX) y_pos <= y_pos + 1'b1;
            end else if (de_in && (x_pos != X_MAX)) begin
                x_pos <= x_pos + 1'b1;
            end
        end
    end

    // Accumulators always restart at frame end; the snapshot is only taken when the divider is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_x    <= '0;
            sum_y    <= '0;
            count    <= '0;
            snap_x   <= '0;
            snap_y   <= '0;
            snap_cnt <= '0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pend    <= 1'b0;
            overrun <= frame_end & engaged;
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
                if (!engaged) begin
                    snap_x   <= sum_x;
                    snap_y   <= sum_y;
                    snap_cnt <= count;
                    pend     <= 1'b1;
                end
            end else if (de_in && mask_in) begin
                sum_x <= sum_x + SUM_W'(x_pos);
                sum_y <= sum_y + SUM_W'(y_pos);
                count <= count + CNT_W'(1);
            end
        end
    end

    assign div_start = ((state == ST_IDLE) && pend && nonempty) ||
                       ((state == ST_DIV_X) && div_done);
    assign div_num   = (state == ST_IDLE) ? snap_x : snap_y;

    serial_divider #(
        .N_W (SUM_W),
        .D_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .numerator   (div_num),
        .denominator (snap_cnt),
        .quotient    (div_quo),
        .done        (div_done)
    );

    // Results load on the edge entering DONE, so they are stable while valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            x_quo    <= '0;
            x_center <= '0;
            y_center <= '0;
            found    <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend) begin
                        if (nonempty) begin
                            state <= ST_DIV_X;
                        end else begin
                            state <= ST_DONE;
                            found <= 1'b0;
                            valid <= 1'b1;
                        end
                    end
                end
                ST_DIV_X: begin
                    if (div_done) begin
                        x_quo <= clamp_coord(div_quo);
                        state <= ST_DIV_Y;
                    end
                end
                ST_DIV_Y: begin
                    if (div_done) begin
                        x_center <= x_quo;
                        y_center <= clamp_coord(div_quo);
                        found    <= 1'b1;
                        valid    <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vp_centroid.sv
// Self-checking bench for vp_centroid on a 16x8 image; a queue holds the
// expected result of each frame and is popped when valid rises.
`timescale 1ns/1ps
module tb_vp_centroid;

    localparam int IMG_W    = 16;
    localparam int IMG_H    = 8;
    localparam int COORD_W  = 4;
    localparam int SUM_W    = 11;
    localparam int CNT_W    = 8;
    localparam int MIN_AREA = 4;
`ifdef VP_CENTROID_MIN_AREA_EN
    localparam int THR = MIN_AREA;
`else
    localparam int THR = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0, mask_in = 1'b0;
    logic [COORD_W-1:0] x_center, y_center;
    logic found, valid, busy, overrun;

    vp_centroid #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W),
        .SUM_W(SUM_W), .CNT_W(CNT_W), .MIN_AREA(MIN_AREA)
    ) dut (
        .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
        .v_sync_in(v_sync_in), .mask_in(mask_in), .x_center(x_center),
        .y_center(y_center), .found(found), .valid(valid), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               found;
        int                 lat;
    } exp_t;

    exp_t               sb[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    logic [IMG_W-1:0]   frame [IMG_H];
    logic [COORD_W-1:0] last_x = '0, last_y = '0;

    task automatic clear_frame();
        for (int l = 0; l < IMG_H; l++) frame[l] = '0;
    endtask

    task automatic drive_frame(output int sx, output int sy, output int cnt);
        sx = 0; sy = 0; cnt = 0;
        for (int l = 0; l < IMG_H; l++) begin
            for (int p = 0; p < IMG_W; p++) begin
                @(negedge clk);
                de_in   = 1'b1;
                mask_in = frame[l][p];
                if (frame[l][p]) begin
                    sx += p; sy += l; cnt++;
                end
            end
            @(negedge clk);
            de_in = 1'b0; mask_in = 1'b0; h_sync_in = 1'b1;
            @(negedge clk);
            h_sync_in = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic push_expected(input int sx, input int sy, input int cnt);
        exp_t e;
        int   qx, qy;
        if (cnt >= THR) begin
            qx = sx / cnt; qy = sy / cnt;
            e.x = (qx > 15) ? 4'hF : 4'(qx);
            e.y = (qy > 15) ? 4'hF : 4'(qy);
            e.found = 1'b1;
            e.lat = 2 * SUM_W + 2;
        end else begin
            e.x = last_x; e.y = last_y;
            e.found = 1'b0;
            e.lat = 2;
        end
        last_x = e.x; last_y = e.y;
        sb.push_back(e);
    endtask

    // Raises v_sync at the current negedge (cycle E) and watches 60 cycles.
    // second_at > 0 raises a second frame end at cycle E+second_at.
    task automatic run_frame_end(input string name, input int second_at, input int exp_over);
        exp_t e;
        int   n_valid = 0, n_over = 0, got_k = -1, busy_k5 = -1;
        logic [COORD_W-1:0] gx = '0, gy = '0;
        logic gf = 1'b0;
        v_sync_in = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (valid) begin
                if (n_valid == 0) begin
                    got_k = k; gx = x_center; gy = y_center; gf = found;
                end
                n_valid++;
            end
            if (overrun) n_over++;
            if (k == 5) busy_k5 = int'(busy);
            if (k == 3) v_sync_in = 1'b0;
            if (second_at > 0 && k == second_at) v_sync_in = 1'b1;
            if (second_at > 0 && k == second_at + 3) v_sync_in = 1'b0;
        end
        e = sb.pop_front();
        n_vec++;
        if (n_valid != 1) begin
            n_err++;
            $display("FAIL %s valid_count: got %0d expected 1", name, n_valid);
        end
        n_vec++;
        if (got_k != e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, got_k, e.lat);
        end
        n_vec++;
        if ({gx, gy, gf} !== {e.x, e.y, e.found}) begin
            n_err++;
            $display("FAIL %s result: got x=%0d y=%0d found=%0b expected x=%0d y=%0d found=%0b",
                     name, gx, gy, gf, e.x, e.y, e.found);
        end
        n_vec++;
        if (n_over != exp_over) begin
            n_err++;
            $display("FAIL %s overrun_count: got %0d expected %0d", name, n_over, exp_over);
        end
        if (e.found) begin
            n_vec++;
            if (busy_k5 != 1) begin
                n_err++;
                $display("FAIL %s busy_during_div: got %0d expected 1", name, busy_k5);
            end
        end
    endtask

    task automatic frame_with(input string name, input int second_at, input int exp_over);
        int sx, sy, cnt;
        drive_frame(sx, sy, cnt);
        push_expected(sx, sy, cnt);
        run_frame_end(name, second_at, exp_over);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({x_center, y_center, found, valid, busy, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {x_center, y_center, found, valid, busy, overrun});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        clear_frame();
        frame[3][5] = 1'b1;
        frame_with("single_5_3", 0, 0);
    endtask

    task automatic test_full_frame();
        for (int l = 0; l < IMG_H; l++) frame[l] = '1;
        frame_with("full_frame", 0, 0);
    endtask

    task automatic test_two_pixels();
        clear_frame();
        frame[0][0]  = 1'b1;
        frame[6][10] = 1'b1;
        frame_with("two_pixels", 0, 0);
    endtask

    task automatic test_empty();
        clear_frame();
        frame_with("empty_frame", 0, 0);
    endtask

    task automatic test_min_area();
        clear_frame();
        frame[1][1] = 1'b1; frame[1][2] = 1'b1; frame[1][3] = 1'b1;
        frame_with("three_pixels", 0, 0);
        clear_frame();
        frame[4][8] = 1'b1; frame[4][9] = 1'b1;
        frame[5][8] = 1'b1; frame[5][9] = 1'b1;
        frame_with("block_8_4", 0, 0);
    endtask

    task automatic test_back_to_back();
        clear_frame();
        frame[3][5] = 1'b1;
        frame_with("overrun", 10, 1);
    endtask

    task automatic test_reset_mid_div();
        int sx, sy, cnt, n_valid = 0;
        clear_frame();
        frame[2][7] = 1'b1;
        drive_frame(sx, sy, cnt);
        v_sync_in = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (valid) n_valid++;
            if (k == 3) v_sync_in = 1'b0;
            if (k == 6) begin
                rst = 1'b1;
                #1;
                n_vec++;
                if ({x_center, y_center, found, valid, busy, overrun} !== '0) begin
                    n_err++;
                    $display("FAIL reset_mid_div_outputs: got %b expected 0",
                             {x_center, y_center, found, valid, busy, overrun});
                end
            end
            if (k == 8) rst = 1'b0;
        end
        last_x = '0; last_y = '0;
        n_vec++;
        if (n_valid != 0) begin
            n_err++;
            $display("FAIL reset_mid_div_valid: got %0d pulses expected 0", n_valid);
        end
        n_vec++;
        if ({x_center, y_center, found, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_div_after: got %b expected 0",
                     {x_center, y_center, found, busy});
        end
    endtask

    initial begin
        clear_frame();
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_two_pixels();
        test_empty();
        test_min_area();
        test_back_to_back();
        test_reset_mid_div();
        test_single_pixel();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
